pdm_demod_cic2: RTL and testbench
=================================

// Module: pdm_demod_cic2
// PURPOSE
//   Receive-side counterpart of the first-order PDM modulator. Recovers multi-bit PCM
//   samples from a 1-bit pulse-density stream.
//   - Filter: 2nd-order CIC decimator (integrate, decimate by R, comb), then saturate/scale.
//   - Output: samples go out on a valid/ready port with a one-entry holding register.
//   - Placement: sits between a PDM pin (or the modulator's output, in loopback) and the sample consumer.
// PARAMETERS
//   LOG2_DECIM  5  decimation R = 2**LOG2_DECIM accepted bits per output sample
//   OUT_W       5  output sample width; legal range 1..2*LOG2_DECIM
// PORTS
//   clk           in   1      single clock, all state on posedge
//   reset_n       in   1      asynchronous, active-low reset
//   pdm_in        in   1      PDM bit
//   pdm_en        in   1      bit strobe: pdm_in accepted on a clk edge only when 1
//   pdm_inv       in   1      (PDM_DEMOD_INVERT_EN only) 1 = stream is complemented
//   sample_out    out  OUT_W  decimated PCM sample, unsigned
//   sample_valid  out  1      sample_out holds an unconsumed sample
//   sample_ready  in   1      consumer accepts; transfer on edge with valid&&ready
//   overrun       out  1      sticky: an unconsumed sample was overwritten
// BEHAVIOUR
//   Reset
//     reset_n=0 asynchronously clears all state: integrators, comb delays, bit counter,
//     dec_stb, warm-up counter, sample_out, sample_valid, overrun.
//     This holds mid-window too: the partial window is discarded.
//   Datapath (W = 2*LOG2_DECIM+1 bits, all arithmetic modulo 2**W)
//     - x = pdm_in (XOR pdm_inv when the macro is defined).
//     - On each edge with pdm_en=1: i1 <= i1+x, i2 <= i2+i1.
//     - Integrator wrap-around is intended. Modular comb differences keep the result exact;
//       there is no saturation inside the integrators.
//   Decimation
//     - bit_cnt (LOG2_DECIM bits) increments on each accepted bit and wraps R-1 -> 0.
//     - Accepting a bit with bit_cnt==R-1 sets dec_stb=1 for exactly the next cycle.
//     - On the edge ending the dec_stb cycle:
//         c1 = i2 - d1,  c2 = c1 - d2,  d1 <= i2,  d2 <= c1.
//       i2 here is the registered value, i.e. it includes exactly the R-th bit.
//     - A bit accepted during the dec_stb cycle belongs to the next window.
//   Scaling
//     - y = min(c2, R*R-1) >> (2*LOG2_DECIM-OUT_W).
//     - Density k/R gives c2 = k*R, so y = k.
//     - All-ones gives c2 = R*R, which saturates to y = 2**OUT_W-1.
//   Warm-up
//     - The first 2 decimation events after reset only prime d1/d2; no sample is produced.
//     - From the 3rd event onward, every event loads y.
//   Latency
//     The R-th bit is captured at edge N; sample_out/sample_valid update at edge N+1.
//   Handshake
//     - A load sets sample_valid=1.
//     - A valid&&ready edge with no load clears sample_valid.
//     - Load and transfer on the same edge: the new sample loads, valid stays 1, no overrun.
//     - Load while valid=1 and ready=0: overwrite sample_out, set overrun=1.
//   overrun
//     Cleared only by reset.
//   sample_out
//     Stable while valid=1, except on the overwrite case above.
//   pdm_en=0
//     Freezes integrators and bit_cnt. The handshake keeps running.
// CONFIGURATION
//   PDM_DEMOD_INVERT_EN
//     - Defined: port pdm_inv exists and x = pdm_in ^ pdm_inv. This decodes the
//       complementary modulator output.
//     - Undefined: no pdm_inv port, x = pdm_in. All other behaviour is identical.
// TESTING (LOG2_DECIM=5, OUT_W=5, pdm_en=1, sample_ready=1 unless stated)
//   1. All-zero stream
//      -> no valid during the first 64 bits; then sample_out=0 every 32 cycles;
//         valid is a 1-cycle pulse.
//   2. All-ones stream
//      -> after warm-up, sample_out=31 (c2=1024 saturated); overrun=0.
//   3. Stream from the first-order modulator with input 12
//      -> steady sample_out=12; the same holds for inputs 0..31.
//   4. All-ones with pdm_en high 1 cycle in 3
//      -> sample_out=31; valid cadence every 96 cycles.
//   5. Density-12 stream, ready=0 across 3 decimation events
//      -> valid held, overrun=1, sample_out=latest; one ready pulse clears valid,
//         overrun stays 1.
//   6. reset_n low for 1 cycle mid-window during test 2
//      -> outputs 0 immediately (async); the next 2 events are suppressed;
//         31 is produced again afterwards.

Source files
------------

// File: rtl/pdm_demod_cic2_if.sv
// Sample output stream of the PDM demodulator.
//   sample_out    decimated PCM sample, unsigned
//   sample_valid  sample_out holds an unconsumed sample
//   sample_ready  consumer accepts; a transfer happens on an edge with valid && ready
//   overrun       sticky flag: an unconsumed sample was overwritten
// The master modport is the demodulator side; the slave modport is the consumer side.
interface pdm_demod_cic2_if #(
  parameter int OUT_W = 5
);
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;

  modport master (
    output sample_out,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );
endinterface

// File: rtl/pdm_demod_cic2.sv
// PDM demodulator: recovers unsigned PCM samples from a 1-bit pulse-density
// stream with a 2nd-order CIC decimator (integrate, decimate by R, comb),
// followed by saturation and scaling into OUT_W bits.
//
// Parameters
//   LOG2_DECIM  decimation R = 2**LOG2_DECIM accepted bits per output sample
//   OUT_W       output sample width, legal range 1..2*LOG2_DECIM
//
// Ports
//   clk       single clock, all state on posedge
//   reset_n   asynchronous active-low reset, discards any partial window
//   pdm_in    PDM bit
//   pdm_en    bit strobe: pdm_in is accepted on an edge only when 1
//   pdm_inv   (PDM_DEMOD_INVERT_EN only) 1 = stream is complemented
//   stream    sample output port (pdm_demod_cic2_if master): sample_out,
//             sample_valid, sample_ready, overrun
//
// Configuration macro
//   PDM_DEMOD_INVERT_EN  adds the pdm_inv port; the accepted bit becomes pdm_in ^ pdm_inv
module pdm_demod_cic2 #(
  parameter int LOG2_DECIM = 5,
  parameter int OUT_W      = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pdm_in,
  input  logic pdm_en,
`ifdef PDM_DEMOD_INVERT_EN
  input  logic pdm_inv,
`endif
  pdm_demod_cic2_if.master stream
);

  // Integrator width: R*R fits exactly, so modular comb differences stay exact.
  localparam int W     = 2 * LOG2_DECIM + 1;
  localparam int SHIFT = 2 * LOG2_DECIM - OUT_W;

  logic                  x;
  logic [W-1:0]          i1, i2;
  logic [W-1:0]          d1, d2;
  logic [W-1:0]          c1, c2;
  logic [W-2:0]          sat;
  logic [OUT_W-1:0]      y;
  logic [LOG2_DECIM-1:0] bit_cnt;
  logic                  dec_stb;
  logic [1:0]            warm;
  logic                  load;

`ifdef PDM_DEMOD_INVERT_EN
  assign x = pdm_in ^ pdm_inv;
`else
  assign x = pdm_in;
`endif

  // Integrators and bit counter. Wrap-around in i1/i2 is intended.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; i2 therefore adds the old i1, exactly as the comb expects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1      <= '0;
      i2      <= '0;
      bit_cnt <= '0;
      dec_stb <= 1'b0;
    end else begin
      if (pdm_en) begin
        i1      <= i1 + W'(x);
        i2      <= i2 + i1;
        bit_cnt <= bit_cnt + LOG2_DECIM'(1);
      end
      // Strobe for exactly the cycle after the R-th bit of a window is taken.
      dec_stb <= pdm_en && (&bit_cnt);
    end
  end

  // Comb stage operates on the registered i2, which already holds the R-th bit.
  assign c1 = i2 - d1;
  assign c2 = c1 - d2;

  // Saturate to R*R-1, then keep the top OUT_W bits.
  // NOTE: sat gets its default before the conditional override, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sat = c2[W-2:0];
    if (c2[W-1]) sat = '1;
  end

  assign y = OUT_W'(sat >> SHIFT);

  // The first two decimation events only prime d1/d2.
  assign load = dec_stb && (warm == 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1   <= '0;
      d2   <= '0;
      warm <= '0;
    end else if (dec_stb) begin
      d1 <= i2;
      d2 <= c1;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  // One-entry holding register. A load wins over a transfer on the same edge;
  // a load onto an unconsumed, unaccepted sample overwrites it and flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stream.sample_out   <= '0;
      stream.sample_valid <= 1'b0;
      stream.overrun      <= 1'b0;
    end else if (load) begin
      stream.sample_out   <= y;
      stream.sample_valid <= 1'b1;
      if (stream.sample_valid && !stream.sample_ready) stream.overrun <= 1'b1;
    end else if (stream.sample_valid && stream.sample_ready) begin
      stream.sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_demod_cic2.sv
// Self-checking bench for pdm_demod_cic2 (LOG2_DECIM=5, OUT_W=5).
// The reference model keeps every accepted bit since reset and computes each
// CIC output directly from the weighted-sum definition of the double
// integrator, then tracks the output handshake at the transaction level.
module tb_pdm_demod_cic2;

  localparam int L     = 5;
  localparam int OUT_W = 5;
  localparam int R     = 1 << L;
  localparam int W     = 2 * L + 1;
  localparam int SH    = 2 * L - OUT_W;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic pdm_in  = 1'b0;
  logic pdm_en  = 1'b0;
`ifdef PDM_DEMOD_INVERT_EN
  logic pdm_inv = 1'b0;
`endif

  pdm_demod_cic2_if #(.OUT_W(OUT_W)) bus ();

  pdm_demod_cic2 #(
    .LOG2_DECIM(L),
    .OUT_W     (OUT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pdm_in (pdm_in),
    .pdm_en (pdm_en),
`ifdef PDM_DEMOD_INVERT_EN
    .pdm_inv(pdm_inv),
`endif
    .stream (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit q[$];          // accepted bits since reset
  int m_n;           // number of accepted bits
  int m_ev;          // decimation events since reset
  bit m_pend;        // a sample is due on the next edge
  int m_pend_y;
  bit m_valid;
  bit m_ovr;
  int m_out;
  int mod_acc;       // first-order modulator accumulator

  // Double-integrator value after n accepted bits: each bit t contributes
  // once per later integration step, i.e. weight n-1-t.
  function automatic longint i2_at(input int n);
    longint s = 0;
    for (int t = 0; t < n; t++) s += longint'(q[t]) * longint'(n - 1 - t);
    return s;
  endfunction

  function automatic int model_y(input int n);
    longint c2;
    c2 = i2_at(n) - 2 * i2_at(n - R) + i2_at(n - 2 * R);
    c2 = c2 & ((longint'(1) << W) - 1);
    if (c2 > longint'(R * R - 1)) c2 = R * R - 1;
    return int'(c2 >> SH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_n = 0; m_ev = 0; m_pend = 0; m_pend_y = 0;
    m_valid = 0; m_ovr = 0; m_out = 0;
    mod_acc = 0;
  endtask

  function automatic bit mod_bit(input int k);
    mod_acc = mod_acc + k;
    mod_bit = (mod_acc >= R);
    mod_acc = mod_acc % R;
  endfunction

  task automatic compare_all();
    check("valid",      32'(bus.sample_valid), 32'(m_valid));
    check("overrun",    32'(bus.overrun),      32'(m_ovr));
    check("sample_out", 32'(bus.sample_out),   32'(m_out));
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare shortly after.
  task automatic cycle(input bit b, input bit en, input bit rdy);
    bit xb;
    @(negedge clk);
    pdm_in = b; pdm_en = en; bus.sample_ready = rdy;
    @(posedge clk);
    if (m_pend) begin
      if (m_valid && !rdy) m_ovr = 1;
      m_out   = m_pend_y;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_pend = 0;
    if (en) begin
      xb = b;
`ifdef PDM_DEMOD_INVERT_EN
      xb = b ^ pdm_inv;
`endif
      q.push_back(xb);
      m_n++;
      if (m_n % R == 0) begin
        m_ev++;
        if (m_ev >= 3) begin
          m_pend   = 1;
          m_pend_y = model_y(m_n);
        end
      end
    end
    #1 compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    pdm_en = 0; bus.sample_ready = 1;
    reset_n = 0;
    #1;
    check("rst_valid",   32'(bus.sample_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun),      32'd0);
    check("rst_out",     32'(bus.sample_out),   32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int ks[4];
    bus.sample_ready = 1'b1;
    model_reset();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    reset_n = 1;

    // 1. All-zero stream.
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 1'b1);
    check("zeros_out", 32'(bus.sample_out), 32'd0);

    // 2. All-ones stream: saturates to full scale.
    do_reset();
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b1);
    check("ones_out",     32'(bus.sample_out), 32'd31);
    check("ones_overrun", 32'(bus.overrun),    32'd0);

    // 3. First-order modulator streams.
    ks[0] = 12; ks[1] = 0; ks[2] = 31; ks[3] = int'($urandom_range(1, 30));
    foreach (ks[j]) begin
      do_reset();
      for (int i = 0; i < 6 * R; i++) cycle(mod_bit(ks[j]), 1'b1, 1'b1);
      check("mod_out", 32'(bus.sample_out), 32'(ks[j]));
    end

    // 4. All-ones with pdm_en high one cycle in three.
    do_reset();
    for (int i = 0; i < 3 * R * 6; i++) cycle(1'b1, (i % 3) == 0, 1'b1);
    check("sparse_out", 32'(bus.sample_out), 32'd31);

    // 5. Density 12 with the consumer stalled across three events.
    do_reset();
    for (int i = 0; i < 5 * R; i++) cycle(mod_bit(12), 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) cycle(mod_bit(12), 1'b1, 1'b0);
    check("stall_valid",   32'(bus.sample_valid), 32'd1);
    check("stall_overrun", 32'(bus.overrun),      32'd1);
    check("stall_out",     32'(bus.sample_out),   32'd12);
    cycle(mod_bit(12), 1'b1, 1'b1);
    check("drain_valid",   32'(bus.sample_valid), 32'd0);
    check("drain_overrun", 32'(bus.overrun),      32'd1);
    for (int i = 0; i < 40; i++) cycle(mod_bit(12), 1'b1, 1'b0);

    // 6. Reset mid-window during an all-ones stream.
    do_reset();
    for (int i = 0; i < 150; i++) cycle(1'b1, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b1);
    check("rerun_out", 32'(bus.sample_out), 32'd31);

    // 7. Random bits, random strobe, random consumer.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));

    // 8. Random modulator level with random strobe and mostly-ready consumer.
    do_reset();
    ks[0] = int'($urandom_range(0, 31));
    for (int i = 0; i < 1500; i++)
      cycle(mod_bit(ks[0]), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
